// File: rtl/axi4_lite_arbiter.sv
// Two-client (I-cache / D-cache) arbiter sharing one AXI4-Lite master port.
// Round-robin grant, latched request, one-cycle response, and a watchdog that faults hung transactions.
module axi4_lite_arbiter #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [AXI_ADDR_WIDTH-1:0] i_addr_i,
   input  logic                      i_start_read_i,
   output logic [AXI_DATA_WIDTH-1:0] i_data_o,
   output logic                      i_done_o,
   output logic                      i_read_fault_o,
   input  logic [AXI_ADDR_WIDTH-1:0] d_addr_i,
   input  logic [AXI_DATA_WIDTH-1:0] d_data_i,
   input  logic                      d_start_read_i,
   input  logic                      d_start_write_i,
   output logic [AXI_DATA_WIDTH-1:0] d_data_o,
   output logic                      d_done_o,
   output logic                      d_read_fault_o,
   output logic                      d_write_fault_o,
   output logic [AXI_ADDR_WIDTH-1:0] m_addr_o,
   output logic [AXI_DATA_WIDTH-1:0] m_data_o,
   output logic                      m_start_read_o,
   output logic                      m_start_write_o,
   input  logic [AXI_DATA_WIDTH-1:0] m_data_i,
   input  logic                      m_done_i,
   input  logic                      m_read_fault_i,
   input  logic                      m_write_fault_i,
   output logic                      busy_o,
   output logic                      grant_d_o
);

   // Counter only needs to reach TIMEOUT_CYCLES-1: the timeout fires on the last allowed BUSY cycle.
   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t          state, state_nxt;
   logic            last_grant;
   logic            op_write;
   logic [WD_W-1:0] wdog;
   logic            req_i, req_d, pick_d, pick_w, finish, timeout;

   always_comb begin
      req_i   = i_start_read_i;
      req_d   = d_start_read_i | d_start_write_i;
      // On a tie the client that did not own the last transaction wins.
      pick_d  = req_d & (~req_i | ~last_grant);
      pick_w  = pick_d & d_start_write_i;
      timeout = (TIMEOUT_CYCLES != 0) && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
      finish  = m_done_i | timeout;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_i | req_d) state_nxt = BUSY;
         BUSY:    if (finish) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_grant      <= 1'b1;
         op_write        <= 1'b0;
         wdog            <= '0;
         grant_d_o       <= 1'b0;
         m_addr_o        <= '0;
         m_data_o        <= '0;
         m_start_read_o  <= 1'b0;
         m_start_write_o <= 1'b0;
         i_data_o        <= '0;
         i_done_o        <= 1'b0;
         i_read_fault_o  <= 1'b0;
         d_data_o        <= '0;
         d_done_o        <= 1'b0;
         d_read_fault_o  <= 1'b0;
         d_write_fault_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_i | req_d) begin
                  grant_d_o       <= pick_d;
                  op_write        <= pick_w;
                  m_addr_o        <= pick_d ? d_addr_i : i_addr_i;
                  m_data_o        <= pick_w ? d_data_i : '0;
                  m_start_read_o  <= ~pick_w;
                  m_start_write_o <= pick_w;
                  wdog            <= '0;
               end
            end
            BUSY: begin
               if (finish) begin
                  m_start_read_o  <= 1'b0;
                  m_start_write_o <= 1'b0;
                  wdog            <= '0;
                  // A real completion beats a simultaneous timeout.
                  if (grant_d_o) begin
                     d_done_o        <= 1'b1;
                     d_data_o        <= (m_done_i && !op_write) ? m_data_i : '0;
                     d_read_fault_o  <= ~op_write & (m_done_i ? m_read_fault_i : 1'b1);
                     d_write_fault_o <= op_write & (m_done_i ? m_write_fault_i : 1'b1);
                  end else begin
                     i_done_o        <= 1'b1;
                     i_data_o        <= m_done_i ? m_data_i : '0;
                     i_read_fault_o  <= m_done_i ? m_read_fault_i : 1'b1;
                  end
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: begin
               i_done_o        <= 1'b0;
               i_read_fault_o  <= 1'b0;
               d_done_o        <= 1'b0;
               d_read_fault_o  <= 1'b0;
               d_write_fault_o <= 1'b0;
               last_grant      <= grant_d_o;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Bench for axi4_lite_arbiter: directed test-plan steps plus randomized transactions
// checked against a transaction-level model (round-robin owner, latched request, response routing).
module tb_axi4_lite_arbiter;
   localparam int AW = 64;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] i_addr, d_addr, m_addr;
   logic          i_start_read, d_start_read, d_start_write;
   logic [DW-1:0] i_data, d_data, d_wdata, m_wdata, m_rdata;
   logic          i_done, i_read_fault, d_done, d_read_fault, d_write_fault;
   logic          m_start_read, m_start_write, m_done, m_read_fault, m_write_fault;
   logic          busy, grant_d;

   int checks = 0;
   int errors = 0;

   // Model state
   bit            last_d;
   logic [DW-1:0] exp_i_data, exp_d_data;

   axi4_lite_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .i_addr_i(i_addr), .i_start_read_i(i_start_read),
      .i_data_o(i_data), .i_done_o(i_done), .i_read_fault_o(i_read_fault),
      .d_addr_i(d_addr), .d_data_i(d_wdata), .d_start_read_i(d_start_read),
      .d_start_write_i(d_start_write),
      .d_data_o(d_data), .d_done_o(d_done), .d_read_fault_o(d_read_fault),
      .d_write_fault_o(d_write_fault),
      .m_addr_o(m_addr), .m_data_o(m_wdata), .m_start_read_o(m_start_read),
      .m_start_write_o(m_start_write),
      .m_data_i(m_rdata), .m_done_i(m_done), .m_read_fault_i(m_read_fault),
      .m_write_fault_i(m_write_fault),
      .busy_o(busy), .grant_d_o(grant_d)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {m_start_read, m_start_write, busy, grant_d, i_done, d_done,
                          i_read_fault, d_read_fault, d_write_fault}, '0);
      chk({tag, "_addr"}, m_addr, '0);
      chk({tag, "_data"}, {m_wdata, i_data, d_data}, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      last_d = 1'b1;
      exp_i_data = '0;
      exp_d_data = '0;
   endtask

   // One complete transaction. Requests are applied in IDLE; the owner is predicted from the
   // round-robin rule, then issue, hold, response and return-to-idle are checked.
   task automatic txn(input bit ri, input bit dr, input bit dw,
                      input logic [AW-1:0] ia, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                      input logic [DW-1:0] rdata, input bit rf, input bit wf,
                      input int lat, input bit hang);
      bit win_d, w, erf, ewf;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] edata;
      int n;
      win_d = (dr | dw) && (!ri || !last_d);
      w     = win_d & dw;
      eaddr = win_d ? da : ia;
      i_start_read = ri; d_start_read = dr; d_start_write = dw;
      i_addr = ia; d_addr = da; d_wdata = dd;
      @(negedge clk);
      chk("issue_grant", grant_d, win_d);
      chk("issue_start", {m_start_read, m_start_write, busy}, {!w, w, 1'b1});
      chk("issue_addr", m_addr, eaddr);
      chk("issue_wdata", m_wdata, w ? dd : '0);
      if (!hang) begin
         for (int k = 1; k < lat; k++) begin
            // Request-side changes during BUSY must not disturb the latched values.
            i_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom}; d_wdata = $urandom;
            @(negedge clk);
            chk("hold", {m_start_read, m_start_write, m_addr, m_wdata},
                {!w, w, eaddr, w ? dd : '0});
         end
         m_done = 1'b1; m_rdata = rdata; m_read_fault = rf; m_write_fault = wf;
         @(negedge clk);
         m_done = 1'b0; m_read_fault = 1'b0; m_write_fault = 1'b0; m_rdata = $urandom;
      end else begin
         n = 1;
         for (int k = 0; k < 40 && (m_start_read || m_start_write); k++) begin
            @(negedge clk);
            if (m_start_read || m_start_write) n++;
         end
         chk("wdog_len", n, TO);
      end
      edata = (w || hang) ? '0 : rdata;
      erf   = !w && (hang || rf);
      ewf   = w && (hang || wf);
      if (win_d) exp_d_data = edata; else exp_i_data = edata;
      chk("resp_done", {i_done, d_done}, {!win_d, win_d});
      chk("resp_data", {i_data, d_data}, {exp_i_data, exp_d_data});
      chk("resp_fault", {i_read_fault, d_read_fault, d_write_fault},
          win_d ? {1'b0, erf, ewf} : {erf, 2'b00});
      chk("resp_start", {m_start_read, m_start_write, busy}, 3'b001);
      i_start_read = 1'b0; d_start_read = 1'b0; d_start_write = 1'b0;
      @(negedge clk);
      chk("idle", {busy, i_done, d_done, i_read_fault, d_read_fault, d_write_fault}, '0);
      last_d = win_d;
   endtask

   initial begin
      bit ri, dr, dw;
      rst_n = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      i_start_read = 1'b0; d_start_read = 1'b0; d_start_write = 1'b0;
      m_rdata = '0; m_done = 1'b0; m_read_fault = 1'b0; m_write_fault = 1'b0;
      do_reset();

      // Single I read, 3-cycle master latency
      txn(1, 0, 0, 64'h0000_0000_8000_0010, '0, '0, 32'hDEADBEEF, 0, 0, 3, 0);

      // Tie right after reset: I first, then D write
      do_reset();
      txn(1, 0, 1, 64'h40, 64'h100, 32'h12345678, 32'hCAFE0001, 0, 0, 2, 0);
      txn(0, 0, 1, 64'h40, 64'h100, 32'h12345678, 32'h0, 0, 0, 2, 0);

      // Continuous requests from both: grants alternate
      for (int k = 0; k < 6; k++)
         txn(1, 1, 0, 64'h1000 + k, 64'h2000 + k, '0, $urandom, 0, 0, 1 + k % 3, 0);

      // Watchdog on a D read, then a stray late completion
      txn(0, 1, 0, '0, 64'h300, '0, '0, 0, 0, 0, 1);
      m_done = 1'b1; m_rdata = 32'hBADBAD00; m_read_fault = 1'b1;
      @(negedge clk);
      m_done = 1'b0; m_read_fault = 1'b0;
      chk("stray_done", {busy, i_done, d_done, m_start_read}, '0);
      @(negedge clk);
      chk("stray_done2", {busy, i_done, d_done, d_read_fault}, '0);

      // D write fault; D read+write together issues write only
      txn(0, 0, 1, '0, 64'h400, 32'hA5A5A5A5, 32'h0, 1, 1, 2, 0);
      txn(0, 1, 1, '0, 64'h500, 32'h5A5A5A5A, 32'h77, 1, 0, 1, 0);

      // Reset while BUSY abandons the transaction
      i_start_read = 1'b1; i_addr = 64'h600;
      @(negedge clk);
      chk("pre_rst_busy", {busy, m_start_read}, 2'b11);
      rst_n = 1'b0; i_start_read = 1'b0;
      @(negedge clk);
      chk_all_zero("mid_rst");
      rst_n = 1'b1;
      last_d = 1'b1; exp_i_data = '0; exp_d_data = '0;
      @(negedge clk);
      chk("post_rst", {busy, i_done, d_done}, '0);
      txn(1, 1, 0, 64'h700, 64'h800, '0, 32'h13579BDF, 0, 0, 2, 0);

      // Randomized transactions against the model
      for (int k = 0; k < 24; k++) begin
         ri = $urandom_range(0, 1); dr = $urandom_range(0, 1); dw = $urandom_range(0, 1);
         if (!(ri || dr || dw)) ri = 1'b1;
         txn(ri, dr, dw, {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom,
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 5),
             ($urandom_range(0, 7) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
